// File: rtl/shell_pool_if.sv
// rtl/shell_pool_if.sv - game-side and renderer-side signal bundle for shell_pool
interface shell_pool_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_SHELLS  = 5,
    parameter int COORD_W     = 6
);
    logic                                      i_clear;
    logic                                      i_frame;
    logic [NUM_PLAYERS-1:0]                    i_fire;
    logic [NUM_PLAYERS*COORD_W-1:0]            i_tank_x;
    logic [NUM_PLAYERS*COORD_W-1:0]            i_tank_y;
    logic [NUM_PLAYERS*2-1:0]                  i_tank_dir;
    logic [NUM_PLAYERS*NUM_SHELLS-1:0]         i_vanish;
    logic [NUM_PLAYERS*NUM_SHELLS*COORD_W-1:0] o_shell_x;
    logic [NUM_PLAYERS*NUM_SHELLS*COORD_W-1:0] o_shell_y;
    logic [NUM_PLAYERS*NUM_SHELLS-1:0]         o_valid;
    logic [NUM_PLAYERS-1:0]                    o_full;
    logic [NUM_PLAYERS-1:0]                    o_spawned;

    modport master (
        output i_clear, i_frame, i_fire, i_tank_x, i_tank_y, i_tank_dir, i_vanish,
        input  o_shell_x, o_shell_y, o_valid, o_full, o_spawned
    );

    modport slave (
        input  i_clear, i_frame, i_fire, i_tank_x, i_tank_y, i_tank_dir, i_vanish,
        output o_shell_x, o_shell_y, o_valid, o_full, o_spawned
    );
endinterface

// File: rtl/shell_pool.sv
// rtl/shell_pool.sv - per-player projectile slot pool advanced once per game tick
module shell_pool #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_SHELLS  = 5,
    parameter int COORD_W     = 6,
    parameter int MAP_X_MAX   = 39,
    parameter int MAP_Y_MAX   = 29,
    parameter int STEP_DIV    = 1,
    parameter int COOLDOWN    = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    shell_pool_if.slave bus
);
    localparam int NSLOT = NUM_PLAYERS * NUM_SHELLS;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int SC_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [COORD_W:0] X_LIM     = (COORD_W+1)'(MAP_X_MAX);
    localparam logic [COORD_W:0] Y_LIM     = (COORD_W+1)'(MAP_Y_MAX);
    localparam logic [SC_W-1:0]  STEP_LAST = SC_W'(STEP_DIV - 1);
    localparam logic [CD_W-1:0]  CD_LOAD   = CD_W'(COOLDOWN);

    logic [NSLOT*COORD_W-1:0]    sx_q, sx_d;
    logic [NSLOT*COORD_W-1:0]    sy_q, sy_d;
    logic [NSLOT*2-1:0]          dir_q, dir_d;
    logic [NSLOT-1:0]            val_q, val_d;
    logic [NUM_PLAYERS-1:0]      pend_q, pend_d;
    logic [NUM_PLAYERS-1:0]      spawned_q, spawned_d;
    logic [NUM_PLAYERS*CD_W-1:0] cd_q, cd_d;
    logic [SC_W-1:0]             step_q, step_d;

    // One extra bit catches both overflow past the map edge and underflow below zero.
    function automatic logic step_cell(
        input  logic [COORD_W-1:0] x,
        input  logic [COORD_W-1:0] y,
        input  logic [1:0]         dir,
        output logic [COORD_W-1:0] nx,
        output logic [COORD_W-1:0] ny
    );
        logic [COORD_W:0] tx;
        logic [COORD_W:0] ty;
        tx = {1'b0, x};
        ty = {1'b0, y};
        case (dir)
            2'd0:    ty = ty - 1'b1;
            2'd1:    ty = ty + 1'b1;
            2'd2:    tx = tx - 1'b1;
            default: tx = tx + 1'b1;
        endcase
        nx = tx[COORD_W-1:0];
        ny = ty[COORD_W-1:0];
        return (tx <= X_LIM) && (ty <= Y_LIM);
    endfunction

    always_comb begin
        logic                adv;
        logic                ok;
        logic                found;
        int                  free_s;
        logic [COORD_W-1:0]  nx;
        logic [COORD_W-1:0]  ny;

        sx_d      = sx_q;
        sy_d      = sy_q;
        dir_d     = dir_q;
        val_d     = val_q;
        cd_d      = cd_q;
        step_d    = step_q;
        spawned_d = '0;
        pend_d    = pend_q | bus.i_fire;
        adv       = (step_q == STEP_LAST);
        ok        = 1'b0;
        found     = 1'b0;
        free_s    = 0;
        nx        = '0;
        ny        = '0;

        if (bus.i_frame) begin
            step_d = adv ? '0 : step_q + 1'b1;
            pend_d = '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                for (int s = 0; s < NUM_SHELLS; s++) begin
                    if (bus.i_vanish[p*NUM_SHELLS+s])
                        val_d[p*NUM_SHELLS+s] = 1'b0;
                    if (adv && val_d[p*NUM_SHELLS+s]) begin
                        ok = step_cell(sx_q[(p*NUM_SHELLS+s)*COORD_W +: COORD_W],
                                       sy_q[(p*NUM_SHELLS+s)*COORD_W +: COORD_W],
                                       dir_q[(p*NUM_SHELLS+s)*2 +: 2], nx, ny);
                        if (ok) begin
                            sx_d[(p*NUM_SHELLS+s)*COORD_W +: COORD_W] = nx;
                            sy_d[(p*NUM_SHELLS+s)*COORD_W +: COORD_W] = ny;
                        end else begin
                            val_d[p*NUM_SHELLS+s] = 1'b0;
                        end
                    end
                end

                // Descending scan leaves the lowest free index selected.
                found  = 1'b0;
                free_s = 0;
                for (int s = NUM_SHELLS - 1; s >= 0; s--) begin
                    if (!val_d[p*NUM_SHELLS+s]) begin
                        found  = 1'b1;
                        free_s = s;
                    end
                end

                ok = step_cell(bus.i_tank_x[p*COORD_W +: COORD_W],
                               bus.i_tank_y[p*COORD_W +: COORD_W],
                               bus.i_tank_dir[p*2 +: 2], nx, ny);
                if ((pend_q[p] || bus.i_fire[p]) && (cd_q[p*CD_W +: CD_W] == '0) && found && ok) begin
                    sx_d[(p*NUM_SHELLS+free_s)*COORD_W +: COORD_W] = nx;
                    sy_d[(p*NUM_SHELLS+free_s)*COORD_W +: COORD_W] = ny;
                    dir_d[(p*NUM_SHELLS+free_s)*2 +: 2]            = bus.i_tank_dir[p*2 +: 2];
                    val_d[p*NUM_SHELLS+free_s]                     = 1'b1;
                    spawned_d[p]                                   = 1'b1;
                    cd_d[p*CD_W +: CD_W]                           = CD_LOAD;
                end else if (cd_q[p*CD_W +: CD_W] != '0) begin
                    cd_d[p*CD_W +: CD_W] = cd_q[p*CD_W +: CD_W] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sx_q      <= '0;
            sy_q      <= '0;
            dir_q     <= '0;
            val_q     <= '0;
            pend_q    <= '0;
            spawned_q <= '0;
            cd_q      <= '0;
            step_q    <= '0;
        end else if (bus.i_clear) begin
            sx_q      <= '0;
            sy_q      <= '0;
            dir_q     <= '0;
            val_q     <= '0;
            pend_q    <= '0;
            spawned_q <= '0;
            cd_q      <= '0;
            step_q    <= '0;
        end else begin
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            dir_q     <= dir_d;
            val_q     <= val_d;
            pend_q    <= pend_d;
            spawned_q <= spawned_d;
            cd_q      <= cd_d;
            step_q    <= step_d;
        end
    end

    assign bus.o_shell_x = sx_q;
    assign bus.o_shell_y = sy_q;
    assign bus.o_valid   = val_q;
    assign bus.o_spawned = spawned_q;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_full
        assign bus.o_full[p] = &val_q[p*NUM_SHELLS +: NUM_SHELLS];
    end
endmodule

// File: doc/shell_pool.md
Name: shell_pool

Overview:
Parametrised successor to the fixed two-player, five-slot shell manager. It holds NUM_PLAYERS × NUM_SHELLS projectile slots and latches fire requests between game ticks. On each frame tick it retires vanished and out-of-map shells, advances live shells and spawns new shells in front of each tank, with a per-player cooldown. It sits between the game state machine (fire, vanish, frame tick) and the VGA renderer (shell positions and valid flags).

Parameters:
NUM_PLAYERS, 2, number of tanks/players
NUM_SHELLS, 5, shell slots per player
COORD_W, 6, width of x/y cell coordinates
MAP_X_MAX, 39, largest legal x cell (inclusive)
MAP_Y_MAX, 29, largest legal y cell (inclusive)
STEP_DIV, 1, shells advance one cell every STEP_DIV frame ticks (≥1)
COOLDOWN, 4, minimum frame ticks between successful spawns per player (0 = none)

Ports:
clk  in  1  game clock (25 MHz domain)
rst_n  in  1  asynchronous active-low reset
i_clear  in  1  synchronous clear of all slots, pending fires, cooldowns and step counter (new round)
i_frame  in  1  one-cycle game-tick pulse
i_fire  in  NUM_PLAYERS  fire request per player; level or pulse, any cycle
i_tank_x  in  NUM_PLAYERS*COORD_W  tank x, player p at [p*COORD_W +: COORD_W]
i_tank_y  in  NUM_PLAYERS*COORD_W  tank y, same packing
i_tank_dir  in  NUM_PLAYERS*2  tank facing: 0 up, 1 down, 2 left, 3 right
i_vanish  in  NUM_PLAYERS*NUM_SHELLS  kill request, slot s of player p at bit p*NUM_SHELLS+s
o_shell_x  out  NUM_PLAYERS*NUM_SHELLS*COORD_W  slot x, packed as for i_vanish, times COORD_W
o_shell_y  out  NUM_PLAYERS*NUM_SHELLS*COORD_W  slot y
o_valid  out  NUM_PLAYERS*NUM_SHELLS  slot live
o_full  out  NUM_PLAYERS  all slots of player p live
o_spawned  out  NUM_PLAYERS  one-cycle pulse: player p spawned a shell this tick

Behaviour:
- Reset (async, rst_n=0): all o_valid=0, o_shell_x/y=0, o_full=0, o_spawned=0, pending fires=0, cooldowns=0, step counter=0. i_clear has the same effect synchronously and takes priority over i_frame in the same cycle.
- Fire latch: i_fire[p]=1 on any cycle sets pending[p]. Pending is consumed (cleared) on the next i_frame, whether or not a spawn results. i_fire high in the same cycle as i_frame counts for that tick.
- i_vanish bits are sampled only on the i_frame cycle; at other times they are ignored.
- Per tick, per player, in this order, all effective in the cycle after i_frame (latency 1; outputs registered):
  1. Vanish: slots with i_vanish set become invalid.
  2. Advance, only if step counter == STEP_DIV-1: each surviving live slot moves one cell in its stored direction. If the move would leave [0..MAP_X_MAX]×[0..MAP_Y_MAX] (including underflow below 0), the slot goes invalid and x/y are held, with no wrap-around. Step counter increments every tick and wraps to 0 after STEP_DIV-1.
  3. Spawn: if pending[p], cooldown[p]==0 and a slot is free after steps 1–2, the lowest-index free slot gets tank position + one cell in i_tank_dir[p], stores that direction and goes valid. Spawned shells do not advance on their spawn tick. If the spawn cell is off-map, there is no spawn, the cooldown is not loaded and o_spawned stays 0.
  4. Cooldown: on a spawn, load COOLDOWN; otherwise decrement if nonzero, once per tick.
- o_full[p] is the AND of player p's o_valid bits after the update. o_spawned is high for exactly the one cycle the new slot appears.
- Each slot stores 2-bit direction internally. Invalid slots keep their last x/y, and downstream must gate on o_valid.
- Players are fully independent. Both players spawning on the same tick is legal. Shell-to-shell and shell-to-tank collision detection lives outside this block, via i_vanish.
- Between ticks all state is frozen except the pending latch.

Test Plan:
1. Reset, then P0 tank (10,10) dir 3, fire pulse, i_frame → cycle after: slot0 valid at (11,10), o_spawned[0]=1 for 1 cycle. Next tick (no fire) → (12,10).
2. COOLDOWN=4, fire held high every tick → spawns on ticks 0, 5, 10 only. After 5 spawns o_full[0]=1; further fires produce no spawn and pending clears each tick.
3. Shell at (39,5) dir 3, tick → slot invalid, x held at 39. Shell at (0,3) dir 2, tick → invalid, no wrap to 63.
4. Vanish slot2 plus fire on the same tick with slots 0–4 full → slot2 freed and respawned at the tank front in that tick, o_full stays 1.
5. Tank (0,7) dir 2, fire → no spawn, o_spawned=0, cooldown stays 0. Fire next tick with dir 3 → spawns at (1,7).
6. STEP_DIV=3: shell advances only on every third tick. Assert i_clear mid-flight → all o_valid=0 next cycle. Assert rst_n low asynchronously between clock edges → outputs clear immediately.
